// File: rtl/gcd_requester_if.sv
// Val/rdy operand and result channels between a gcd traffic generator and a gcd unit.
interface gcd_requester_if #(
  parameter int W = 16
);
  logic [W-1:0] operands_bits_A;
  logic [W-1:0] operands_bits_B;
  logic         operands_val;
  logic         operands_rdy;
  logic [W-1:0] result_bits_data;
  logic         result_val;
  logic         result_rdy;

  modport master (
    output operands_bits_A, operands_bits_B, operands_val,
    input  operands_rdy,
    input  result_bits_data, result_val,
    output result_rdy
  );

  modport slave (
    input  operands_bits_A, operands_bits_B, operands_val,
    output operands_rdy,
    output result_bits_data, result_val,
    input  result_rdy
  );
endinterface

// File: rtl/gcd_requester.sv
// Issues LFSR operand pairs to a gcd unit one at a time, folds results into a
// rotating checksum and tracks the worst operand-to-result latency.
module gcd_requester #(
  parameter int             W      = 16,
  parameter int             CNT_W  = 16,
  parameter logic [W-1:0]   SEED_A = 16'h1234,
  parameter logic [W-1:0]   SEED_B = 16'h00F0,
  parameter logic [W-1:0]   POLY   = 16'hB400
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_ops,
  input  logic [3:0]        rdy_delay,
  gcd_requester_if.master   bus,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  ops_sent,
  output logic [CNT_W-1:0]  results_recv,
  output logic [W-1:0]      checksum,
  output logic [CNT_W-1:0]  max_latency
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

  state_t           state;
  logic [W-1:0]     lfsr_a, lfsr_b;
  logic [CNT_W-1:0] num_ops_q;
  logic [CNT_W-1:0] lat_cnt;
  logic [3:0]       rdy_delay_q;
  logic [3:0]       stall_cnt;
  logic             operands_val_q;
  logic             result_rdy_q;

  logic             op_fire, res_fire;
  logic [CNT_W-1:0] recv_next;
  logic [CNT_W-1:0] latency;
  logic [3:0]       stall_next;

  function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] x);
    return x[0] ? ((x >> 1) ^ POLY) : (x >> 1);
  endfunction

  assign bus.operands_bits_A = lfsr_a;
  assign bus.operands_bits_B = lfsr_b;
  assign bus.operands_val    = operands_val_q;
  assign bus.result_rdy      = result_rdy_q;

  always_comb begin
    op_fire    = (state == SEND) && operands_val_q && bus.operands_rdy;
    res_fire   = (state == WAIT) && bus.result_val && result_rdy_q;
    recv_next  = results_recv + CNT_W'(1);
    // Latency reported is 1 + counter, clamped so a saturated counter stays all-ones.
    latency    = (lat_cnt == '1) ? lat_cnt : lat_cnt + CNT_W'(1);
    stall_next = (stall_cnt == 4'hF) ? stall_cnt : stall_cnt + 4'd1;
  end

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      lfsr_a         <= SEED_A;
      lfsr_b         <= SEED_B;
      num_ops_q      <= '0;
      rdy_delay_q    <= '0;
      lat_cnt        <= '0;
      stall_cnt      <= '0;
      operands_val_q <= 1'b0;
      result_rdy_q   <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      ops_sent       <= '0;
      results_recv   <= '0;
      checksum       <= '0;
      max_latency    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            lfsr_a       <= SEED_A;
            lfsr_b       <= SEED_B;
            num_ops_q    <= num_ops;
            rdy_delay_q  <= rdy_delay;
            ops_sent     <= '0;
            results_recv <= '0;
            checksum     <= '0;
            max_latency  <= '0;
            if (num_ops != '0) begin
              state          <= SEND;
              operands_val_q <= 1'b1;
              busy           <= 1'b1;
              done           <= 1'b0;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end

        SEND: begin
          if (op_fire) begin
            ops_sent       <= ops_sent + CNT_W'(1);
            lfsr_a         <= lfsr_step(lfsr_a);
            lfsr_b         <= lfsr_step(lfsr_b);
            lat_cnt        <= '0;
            stall_cnt      <= '0;
            operands_val_q <= 1'b0;
            result_rdy_q   <= (rdy_delay_q == 4'd0);
            state          <= WAIT;
          end
        end

        WAIT: begin
          if (lat_cnt != '1) lat_cnt <= lat_cnt + CNT_W'(1);
          if (res_fire) begin
            checksum     <= {checksum[W-2:0], checksum[W-1]} ^ bus.result_bits_data;
            results_recv <= recv_next;
            max_latency  <= (latency > max_latency) ? latency : max_latency;
            result_rdy_q <= 1'b0;
            if (recv_next == num_ops_q) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state          <= SEND;
              operands_val_q <= 1'b1;
            end
          end else if (bus.result_val) begin
            // Here result_rdy_q is low, so this cycle is a stall.
            stall_cnt    <= stall_next;
            result_rdy_q <= (stall_next >= rdy_delay_q);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_requester.sv
// Self-checking bench: a behavioural gcd responder on the slave side, a table of
// runs checked against an arithmetic model, plus hand-written reset/start sequences.
module tb_gcd_requester;
  localparam int W     = 16;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] num_ops;
  logic [3:0]       rdy_delay;
  logic             busy, done;
  logic [CNT_W-1:0] ops_sent, results_recv, max_latency;
  logic [W-1:0]     checksum;

  gcd_requester_if #(.W(W)) bus();

  gcd_requester #(.W(W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .num_ops      (num_ops),
    .rdy_delay    (rdy_delay),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .ops_sent     (ops_sent),
    .results_recv (results_recv),
    .checksum     (checksum),
    .max_latency  (max_latency)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] lfsr_f(input logic [W-1:0] x);
    return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
  endfunction

  function automatic logic [W-1:0] gcd_f(input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned x, y, t;
    x = a; y = b;
    while (y != 0) begin
      t = x % y; x = y; y = t;
    end
    return W'(x);
  endfunction

  function automatic logic [W-1:0] model_checksum(input int n, input logic [W-1:0] fixed);
    logic [W-1:0] a, b, s, r;
    a = 16'h1234; b = 16'h00F0; s = '0;
    for (int i = 0; i < n; i++) begin
      r = (fixed != 0) ? fixed : gcd_f(a, b);
      s = W'((s << 1) | (s >> (W - 1))) ^ r;
      a = lfsr_f(a);
      b = lfsr_f(b);
    end
    return s;
  endfunction

  // ---------------- gcd responder (slave side) ----------------
  int           cfg_delay = 0;
  bit           cfg_rand_rdy = 1'b0;
  logic [W-1:0] cfg_fixed = '0;
  int           cfg_rdy_delay = 0;
  bit           resp_clear = 1'b0;

  bit           s_busy, presenting, op_pred, res_pred, val_wait;
  int           s_cnt, stalls, op_count, res_count;
  logic [W-1:0] s_res, hold_a, hold_b, m_a, m_b;
  int unsigned  op_edge, obs_max_lat, lat;

  initial begin
    bus.operands_rdy     = 1'b0;
    bus.result_val       = 1'b0;
    bus.result_bits_data = '0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 || resp_clear) begin
        s_busy = 0; presenting = 0; op_pred = 0; res_pred = 0; val_wait = 0;
        bus.operands_rdy = 1'b0;
        bus.result_val   = 1'b0;
        resp_clear = 1'b0;
      end else begin
        if (op_pred) begin
          check("pair_a", hold_a, m_a);
          check("pair_b", hold_b, m_b);
          m_a = lfsr_f(m_a);
          m_b = lfsr_f(m_b);
          s_res  = (cfg_fixed != 0) ? cfg_fixed : gcd_f(hold_a, hold_b);
          s_busy = 1; s_cnt = cfg_delay; stalls = 0;
          op_count++;
        end
        if (res_pred) begin
          s_busy = 0; presenting = 0;
          res_count++;
        end
        if (!s_busy) begin
          bus.operands_rdy     = cfg_rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
          bus.result_val       = cfg_rand_rdy ? 1'($urandom_range(0, 1)) : 1'b0;
          bus.result_bits_data = 16'hDEAD;
          if (bus.result_val) check("rdy_outside_wait", bus.result_rdy, 0);
        end else begin
          bus.operands_rdy = 1'b0;
          if (!presenting) begin
            if (s_cnt == 0) presenting = 1;
            else s_cnt--;
          end
          bus.result_val       = presenting;
          bus.result_bits_data = presenting ? s_res : 16'hDEAD;
          if (presenting && !bus.result_rdy) stalls++;
        end
        if (val_wait && bus.operands_val) begin
          check("op_stable_a", bus.operands_bits_A, hold_a);
          check("op_stable_b", bus.operands_bits_B, hold_b);
        end
        op_pred  = bus.operands_val && bus.operands_rdy;
        val_wait = bus.operands_val && !bus.operands_rdy;
        hold_a   = bus.operands_bits_A;
        hold_b   = bus.operands_bits_B;
        if (op_pred) op_edge = cyc + 1;
        res_pred = bus.result_val && bus.result_rdy;
        if (res_pred && presenting) begin
          check("stall_cycles", stalls, cfg_rdy_delay);
          lat = cyc + 1 - op_edge;
          if (lat > obs_max_lat) obs_max_lat = lat;
        end
      end
    end
  end

  // ---------------- helper tasks ----------------
  task automatic check_reset_values(input string tag);
    check({tag, "_val"},   bus.operands_val, 0);
    check({tag, "_rrdy"},  bus.result_rdy, 0);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_done"},  done, 0);
    check({tag, "_sent"},  ops_sent, 0);
    check({tag, "_recv"},  results_recv, 0);
    check({tag, "_sum"},   checksum, 0);
    check({tag, "_maxl"},  max_latency, 0);
    check({tag, "_a"},     bus.operands_bits_A, 16'h1234);
    check({tag, "_b"},     bus.operands_bits_B, 16'h00F0);
  endtask

  task automatic start_run(input int n, input int rd);
    m_a = 16'h1234; m_b = 16'h00F0;
    op_count = 0; res_count = 0; obs_max_lat = 0;
    cfg_rdy_delay = rd;
    resp_clear = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    start = 1'b1; num_ops = CNT_W'(n); rdy_delay = 4'(rd);
    @(posedge clk); #1;
    start = 1'b0;
    if (n == 0) begin
      check("zero_done", done, 1);
      check("zero_val", bus.operands_val, 0);
      check("zero_busy", busy, 0);
    end else begin
      check("start_val", bus.operands_val, 1);
      check("start_busy", busy, 1);
      check("start_done", done, 0);
      check("start_a", bus.operands_bits_A, 16'h1234);
      check("start_b", bus.operands_bits_B, 16'h00F0);
      check("start_cleared", {ops_sent, results_recv}, 0);
      check("start_sum_clr", checksum, 0);
    end
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("done_reached", done, 1);
  endtask

  task automatic finish_checks(input int n, input logic [W-1:0] exp_sum);
    check("ops_sent", ops_sent, n);
    check("results_recv", results_recv, n);
    check("handshakes_seen", op_count, n);
    check("checksum", checksum, exp_sum);
    check("max_latency", max_latency, obs_max_lat);
    check("end_busy", busy, 0);
    check("end_val", bus.operands_val, 0);
    check("end_rrdy", bus.result_rdy, 0);
  endtask

  // ---------------- table of runs ----------------
  typedef struct {
    int           n;
    int           rd;
    int           gdelay;
    bit           rand_rdy;
    logic [W-1:0] fixed;
    bit           has_exp;
    logic [W-1:0] exp_sum;
    int           exp_lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; num_ops = '0; rdy_delay = '0;

    // Asynchronous reset between edges.
    #12 reset = 1'b1;
    #1 check_reset_values("rst");
    @(negedge clk); #2 reset = 1'b0;

    vecs[0] = '{2, 0, 3, 1'b0, 16'h0000, 1'b1, 16'h0022, 4};
    vecs[1] = '{1, 3, 1, 1'b0, 16'h0005, 1'b1, 16'h0005, 5};
    vecs[2] = '{0, 5, 0, 1'b0, 16'h0000, 1'b1, 16'h0000, 0};
    vecs[3] = '{3, 15, 0, 1'b1, 16'h0000, 1'b0, 16'h0000, 0};
    for (int i = 4; i < 10; i++)
      vecs[i] = '{int'($urandom_range(1, 6)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 4)), 1'b1, 16'h0000, 1'b0, 16'h0000, 0};

    for (int i = 0; i < 10; i++) begin
      cfg_delay    = vecs[i].gdelay;
      cfg_rand_rdy = vecs[i].rand_rdy;
      cfg_fixed    = vecs[i].fixed;
      start_run(vecs[i].n, vecs[i].rd);
      wait_done(3000);
      finish_checks(vecs[i].n, model_checksum(vecs[i].n, vecs[i].fixed));
      if (vecs[i].has_exp) begin
        check("table_checksum", checksum, vecs[i].exp_sum);
        check("table_max_latency", max_latency, vecs[i].exp_lat);
      end
    end

    // DONE holds its status.
    repeat (3) @(posedge clk);
    #1 check("done_hold", done, 1);

    // start during WAIT of a 3-op run is ignored.
    cfg_delay = 4; cfg_rand_rdy = 1'b0; cfg_fixed = '0;
    start_run(3, 2);
    begin
      int k = 0;
      while (!s_busy && k < 100) begin @(negedge clk); k++; end
      check("reached_wait", s_busy, 1);
    end
    @(posedge clk); #1 start = 1'b1; num_ops = 16'd9;
    @(posedge clk); #1 start = 1'b0;
    check("ignored_start_busy", busy, 1);
    check("ignored_start_sent", ops_sent, 1);
    wait_done(3000);
    finish_checks(3, model_checksum(3, '0));

    // Reset in WAIT of op 2 of 4, then restart a 1-op run.
    cfg_delay = 3;
    start_run(4, 1);
    begin
      int k = 0;
      while (!(op_count == 2 && s_busy) && k < 200) begin @(negedge clk); k++; end
      check("reached_op2_wait", op_count, 2);
    end
    @(negedge clk); #2 reset = 1'b1;
    #1 check_reset_values("midrst");
    @(negedge clk); #2 reset = 1'b0;
    start_run(1, 0);
    wait_done(3000);
    finish_checks(1, model_checksum(1, '0));
    check("restart_checksum", checksum, 16'h0014);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gcd_requester.md
# gcd_requester

Traffic generator and result collector that drives the operand side and consumes the result side of the `gcd` unit's val/rdy interface. On a start command it issues `num_ops` pseudo-random operand pairs from two LFSRs, one transaction at a time. It accepts each result with programmable back-pressure and folds it into an order-sensitive checksum. It records the worst-case per-transaction latency. It sits beside a `gcd` instance in test/e2e harnesses and bring-up tops.

## Interface
- `W`, 16: operand/result width.
- `CNT_W`, 16: width of op counters and latency counter.
- `SEED_A`, 16'h1234: LFSR A reset/reload value; must be nonzero.
- `SEED_B`, 16'h00F0: LFSR B reset/reload value; must be nonzero.
- `POLY`, 16'hB400: Galois LFSR tap mask, shared by both LFSRs.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle command; sampled only in IDLE or DONE.
- `num_ops`  in  CNT_W  transaction count, latched when `start` is accepted.
- `rdy_delay`  in  4  result back-pressure, latched when `start` is accepted.
- `operands_bits_A`  out  W  current LFSR A value.
- `operands_bits_B`  out  W  current LFSR B value.
- `operands_val`  out  1  operand pair valid.
- `operands_rdy`  in  1  `gcd` accepts the pair.
- `result_bits_data`  in  W  `gcd` result.
- `result_val`  in  1  result valid.
- `result_rdy`  out  1  requester accepts the result.
- `busy`  out  1  high in SEND and WAIT.
- `done`  out  1  high in DONE (level).
- `ops_sent`  out  CNT_W  operand handshakes completed.
- `results_recv`  out  CNT_W  result handshakes completed.
- `checksum`  out  W  accumulated result signature.
- `max_latency`  out  CNT_W  worst latency in the run.

## Operation
- States: IDLE, SEND, WAIT, DONE.
- IDLE/DONE + `start`:
  - Clear `ops_sent`, `results_recv`, `checksum` and `max_latency`.
  - Reload both LFSRs with their seeds.
  - Latch `num_ops` and `rdy_delay`.
  - Go to SEND if `num_ops` != 0; otherwise go to (or stay in) DONE.
- SEND:
  - `operands_val`=1.
  - When `operands_rdy` is high, the operand handshake fires:
    - `ops_sent`++.
    - Step both LFSRs: `x = x[0] ? (x>>1)^POLY : x>>1`.
    - Clear the latency counter and the stall counter.
    - Go to WAIT.
- WAIT:
  - Latency counter increments every cycle, saturating at all-ones.
  - The stall counter increments on each cycle with `result_val`=1 and `result_rdy`=0, saturating at 15.
  - `result_rdy` = (stall counter >= latched `rdy_delay`). With `rdy_delay`=0, `result_rdy` is high on WAIT entry.
  - When `result_val` and `result_rdy` are both high, the result handshake fires:
    - `checksum <= {checksum[W-2:0], checksum[W-1]} ^ result_bits_data`.
    - `results_recv`++.
    - `max_latency <= max(max_latency, latency)`, where latency = cycles from the operand-fire edge to the result-fire edge, counted as 1 + the latency counter value.
    - Go to DONE if `results_recv`+1 == latched `num_ops`, else go to SEND.
- DONE: holds all status outputs until `start` or reset.
- `start` in SEND or WAIT is ignored.
- The only way to abort a run is `reset`.
- `result_val` outside WAIT is ignored; `result_rdy`=0 there.
- Counter arithmetic is modulo 2^CNT_W, except the latency counter, which saturates.

## Timing
- Reset values:
  - state IDLE.
  - `operands_val`=0, `result_rdy`=0, `busy`=0, `done`=0.
  - All counters, `checksum` and `max_latency` = 0.
  - LFSR A = `SEED_A`, LFSR B = `SEED_B`.
- All outputs are decoded from registers only; no input-to-output combinational path.
- `start` accepted at edge t: SEND visible in the cycle after t, with `operands_val`=1 and the first pair = seeds.
- Operand bits are stable while `operands_val`=1.
- SEND→WAIT takes exactly one edge after the operand fire. `operands_val` is low in the following cycle, so there are no back-to-back issues.
- Result fire → next SEND in the following cycle. Minimum transaction spacing is 2 cycles plus the `gcd` compute time.
- Asynchronous `reset` mid-run immediately forces the reset values above. The run is lost and must be restarted.

## Test plan
- Reset: assert `reset` asynchronously between edges -> all outputs at reset values immediately; operand bits = 16'h1234 / 16'h00F0.
- Two-op run, `rdy_delay`=0, real `gcd`:
  - Pairs issued: (0x1234, 0x00F0), then (0x091A, 0x0078).
  - Results: 0x0014, then 0x000A.
  - Final `checksum`=0x0022, `ops_sent`=`results_recv`=2, `done`=1.
- `num_ops`=0 start -> DONE next cycle, `operands_val` never asserted, counters 0.
- Back-pressure, `rdy_delay`=3, stub `gcd` returns 0x0005 two cycles after accept:
  - `result_rdy` first high on the 4th cycle of `result_val`.
  - Fire on that cycle; `max_latency`=5.
- `start` pulsed during WAIT of a 3-op run -> ignored; run completes with `ops_sent`=3.
- Reset asserted in WAIT of op 2 of 4, then restart with `num_ops`=1 -> first pair is again (0x1234, 0x00F0) and `checksum`=0x0014.
